// File: rtl/umac_pkg.sv
// umac_pkg: state type, default widths and signed accumulator bounds shared by the umac cells
package umac_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int WIDTH_DEF = 16;
    localparam int LEN_W_DEF = 16;
    localparam int ACC_W_DEF = 16;
    function automatic int acc_max(input int acc_w);
        return (1 << (acc_w - 1)) - 1;
    endfunction
    function automatic int acc_min(input int acc_w);
        return -(1 << (acc_w - 1));
    endfunction
endpackage

// File: rtl/umac_acc.sv
// umac_acc: signed up/down counter with clear; with UMAC_INNER_SAT_EN defined it clamps
// at the signed limits, otherwise it wraps.
module umac_acc
    import umac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             dir,
    output logic [ACC_W-1:0] acc
);
    logic [ACC_W-1:0] nxt;
`ifdef UMAC_INNER_SAT_EN
    localparam logic [ACC_W-1:0] MAX = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN = ACC_W'(acc_min(ACC_W));
    always_comb nxt = dir ? (acc == MIN ? acc : acc - 1'b1) : (acc == MAX ? acc : acc + 1'b1);
`else
    always_comb nxt = dir ? acc - 1'b1 : acc + 1'b1;
`endif
    always_ff @(posedge clk) begin
        if (rst || clear) acc <= '0;
        else if (enable) acc <= nxt;
    end
endmodule

// File: rtl/umac_inner.sv
// umac_inner: unary-temporal MAC cell with stationary sign-magnitude weight, systolic forwarding
// and windowed signed accumulation; UMAC_INNER_SAT_EN selects a saturating accumulator.
module umac_inner
    import umac_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_w_load,
    input  logic [WIDTH-1:0] i_data_w,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic             i_bit_i,
    input  logic             i_sign_i,
    input  logic [WIDTH-2:0] i_randW,
    output logic [WIDTH-2:0] o_randW,
    output logic             o_bit_i,
    output logic             o_sign_i,
    output logic             o_bit,
    output logic             o_sign,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_valid,
    output logic             o_busy
);
    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic             w_sign;
    logic [WIDTH-2:0] w_mag;
    logic             start_ok;

    assign start_ok = state == IDLE && i_start;
    assign o_bit    = i_bit_i & (w_mag > o_randW);
    assign o_sign   = i_sign_i ^ w_sign;
    assign o_busy   = state == RUN;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            w_sign   <= 1'b0;
            w_mag    <= '0;
            o_randW  <= '0;
            o_bit_i  <= 1'b0;
            o_sign_i <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            o_randW  <= i_randW;
            o_bit_i  <= i_bit_i;
            o_sign_i <= i_sign_i;
            o_valid  <= 1'b0;
            if (i_w_load && state == IDLE) {w_sign, w_mag} <= i_data_w;
            if (state == IDLE) begin
                if (i_start) begin
                    cnt <= i_len;
                    if (i_len == '0) o_valid <= 1'b1;
                    else state <= RUN;
                end
            end else begin
                // the last counted cycle is still accumulated by umac_acc on this same edge
                cnt <= cnt - 1'b1;
                if (cnt == LEN_W'(1)) begin
                    state   <= IDLE;
                    o_valid <= 1'b1;
                end
            end
        end
    end

    umac_acc #(.ACC_W(ACC_W)) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (start_ok),
        .enable (o_busy && o_bit),
        .dir    (o_sign),
        .acc    (o_acc)
    );
endmodule

// File: doc/umac_inner.md
# umac_inner

Parametrised unary-temporal multiply-accumulate cell for the systolic array. It holds a stationary sign-magnitude weight. Each cycle it compares the weight magnitude against a registered random number forwarded between neighbouring cells, and ANDs the result with the incoming input bitstream. Unlike the plain multiply cell, it also forwards the input bit and input sign systolically, and accumulates the signed product bits over a programmable window into a signed count with a valid pulse.

## Interface
- WIDTH, 16, weight width including sign (MSB = sign, WIDTH-1 magnitude bits)
- LEN_W, 16, width of window-length input
- ACC_W, 16, accumulator width, two's complement
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- i_w_load  in  1  load weight register from i_data_w
- i_data_w  in  WIDTH  sign-magnitude weight
- i_start  in  1  start an accumulation window
- i_len  in  LEN_W  window length in cycles, sampled with i_start
- i_bit_i  in  1  input bitstream bit
- i_sign_i  in  1  input sign
- i_randW  in  WIDTH-1  random number from upstream cell
- o_randW  out  WIDTH-1  i_randW delayed one cycle
- o_bit_i  out  1  i_bit_i delayed one cycle
- o_sign_i  out  1  i_sign_i delayed one cycle
- o_bit  out  1  product bit (combinational)
- o_sign  out  1  product sign (combinational)
- o_acc  out  ACC_W  accumulated result
- o_valid  out  1  one-cycle pulse when o_acc is final
- o_busy  out  1  high while state is RUN

## Operation
- **Weight register:** w_sign and w_mag.
  - Loaded on i_w_load when not busy.
  - i_w_load while busy is ignored; the weight is unchanged.
- **Product logic:**
  - o_bit = i_bit_i & (w_mag > o_randW), unsigned compare.
  - o_sign = i_sign_i ^ w_sign.
  - Both are ungated by state.
- **FSM states:** IDLE, RUN.
  - IDLE + i_start, i_len ≥ 1: cnt <= i_len, acc <= 0, go to RUN.
  - IDLE + i_start, i_len = 0: acc <= 0, o_valid pulses next cycle, stay IDLE.
  - RUN, every cycle: if o_bit, acc += (o_sign ? -1 : +1); cnt decrements.
  - RUN with cnt = 1: the update is applied, then go to IDLE and pulse o_valid next cycle.
- i_start while in RUN is ignored.
- **o_acc:**
  - Shows the running value during RUN.
  - Holds the final value from o_valid until the next accepted i_start.
- **Reset values:** o_randW, o_bit_i, o_sign_i, o_acc, o_valid, o_busy, cnt and weight are all 0; state is IDLE.
- **Reset mid-window:** the window is abandoned, no o_valid is produced, and all outputs return to their reset values next cycle.

## Timing
- o_randW, o_bit_i and o_sign_i have 1-cycle latency and update every cycle regardless of state.
- o_bit and o_sign have 0-cycle latency from i_bit_i, i_sign_i, the weight, and o_randW.
- **Window timing:**
  - i_start accepted at cycle t.
  - o_bit is accumulated in cycles t+1 .. t+L.
  - o_valid and the final o_acc appear at cycle t+L+1, with state back in IDLE.
- **Back-to-back windows:** i_start in the o_valid cycle is accepted, giving no gap cycle.
- A weight load at cycle t is visible to o_bit at t+1.

## Configuration
- **UMAC_INNER_SAT_EN defined:** the accumulator saturates at +2^(ACC_W-1)-1 and at -2^(ACC_W-1).
  - Once saturated, it stays clamped unless a bit of the opposite sign moves it back.
- **Undefined:** two's-complement wrap-around.

## Structure
- **Package umac_pkg:**
  - State enum (IDLE, RUN).
  - Default width constants.
  - ACC_MAX and ACC_MIN functions of ACC_W.
- **Sub-module umac_acc:** signed up/down counter.
  - Ports: clear, enable, direction.
  - Contains the UMAC_INNER_SAT_EN clamp logic.
- Top-level umac_inner contains the FSM, window counter, weight register and systolic forwarding registers.

## Test plan
- **Positive product:** WIDTH=16. Load weight +10, i_start with i_len=32, i_bit_i=1, i_sign_i=0. Drive o_randW as 0..31 across the RUN cycles. Expect o_acc=10, o_valid exactly at start+33, o_busy high for 32 cycles.
- **Negative product:** same stimulus with weight sign=1, or input sign=1. Expect o_acc=-10. With both signs set, expect +10.
- **Saturation:** ACC_W=4, weight magnitude 0x7FFF, i_len=16, i_bit_i=1, o_randW=0. With UMAC_INNER_SAT_EN, expect o_acc=7. Without it, expect o_acc=0 (wrap).
- **Zero-length window:** i_start with i_len=0. Expect o_valid at the next cycle, o_acc=0, o_busy never high.
- **Reset mid-window and busy load:** assert rst during RUN at cycle 5 of 32. Expect all outputs 0 next cycle and no o_valid. Separately, i_w_load while busy leaves the weight unchanged.
- **Forwarding and back-to-back:** i_randW, i_bit_i and i_sign_i appear on their outputs 1 cycle later. i_start in the o_valid cycle begins the next window with no gap, and o_acc restarts from 0.
